// File: rtl/u_tx_if.sv
// u_tx_if: request and serial-bit handshake bundle for the u_tx thermometer transmitter.
// The slave modport is the transmitter. The master modport is whoever drives the requests
// and takes the bits.
interface u_tx_if #(
    parameter int W = 8
);
    localparam int CW = $clog2(W + 1);

    logic          i_in_vld;
    logic [CW-1:0] i_in_cnt;
    logic          i_in_inv;
    logic          o_in_rdy;
    logic          o_ser_vld;
    logic          o_ser_bit;
    logic          o_ser_last;
    logic          i_ser_rdy;
    logic          o_busy;

    modport slave (
        input  i_in_vld, i_in_cnt, i_in_inv, i_ser_rdy,
        output o_in_rdy, o_ser_vld, o_ser_bit, o_ser_last, o_busy
    );

    modport master (
        output i_in_vld, i_in_cnt, i_in_inv, i_ser_rdy,
        input  o_in_rdy, o_ser_vld, o_ser_bit, o_ser_last, o_busy
    );
endinterface

// File: rtl/u_tx.sv
// u_tx: serial transmitter for W-bit unary (thermometer) codes, sent LSB first.
// A binary count is accepted over valid/ready. W bits follow on a valid/ready serial
// port, and the last bit is flagged.
// Optional feature: define U_TX_COMPLIMENT_EN to honour i_in_inv, which selects the
// complimented code. Without it, inv is tied low and the port is ignored.
module u_tx #(
    parameter int W = 8
) (
    input logic   i_clk,
    input logic   i_arst_n,
    u_tx_if.slave bus
);
    localparam int CW = $clog2(W + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic [CW-1:0] W_C    = CW'(W);
    localparam logic [CW-1:0] LAST_C = CW'(W - 1);

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          inv_q, inv_d;

    logic [CW-1:0] cnt_sat;
    logic          inv_in;
    logic          is_last;
    logic          in_shift;

    // Oversized counts clamp to an all-ones code. No error is reported.
    assign cnt_sat = (bus.i_in_cnt > W_C) ? W_C : bus.i_in_cnt;

`ifdef U_TX_COMPLIMENT_EN
    assign inv_in = bus.i_in_inv;
`else
    // The port stays on the interface so both builds look identical from outside.
    logic unused_inv;
    assign unused_inv = bus.i_in_inv;
    assign inv_in     = 1'b0;
`endif

    assign in_shift = (state_q == ST_SHIFT);
    assign is_last  = (idx_q == LAST_C);

    // Output decode: everything is quiet in IDLE, and bits are driven straight from the state in SHIFT.
    always_comb begin
        bus.o_in_rdy   = !in_shift;
        bus.o_busy     = in_shift;
        bus.o_ser_vld  = in_shift;
        bus.o_ser_bit  = in_shift & ((idx_q < cnt_q) ^ inv_q);
        bus.o_ser_last = in_shift & is_last;
    end

    // Next state: latch the request in IDLE, and advance one bit per serial handshake in SHIFT.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        inv_d   = inv_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_in_vld) begin
                    state_d = ST_SHIFT;
                    cnt_d   = cnt_sat;
                    inv_d   = inv_in;
                    idx_d   = '0;
                end
            end
            default: begin
                if (bus.i_ser_rdy) begin
                    if (is_last) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + CW'(1);
                    end
                end
            end
        endcase
    end

    // State registers. Reset aborts any code in flight.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            inv_q   <= inv_d;
        end
    end
endmodule

// File: tb/tb_u_tx.sv
// tb_u_tx: table of requests with expected bit codes, plus a serial scoreboard and a few
// hand-written sequences for latency, back-to-back requests, ignored requests and mid-code reset.
module tb_u_tx;
    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    typedef struct {
        int       cnt;
        bit       inv;
        int       mode;   // 0: rdy always high, 1: rdy pattern 1,0,0, 2: random rdy
        bit [W-1:0] exp;  // bit 0 is sent first
    } vec_t;

    typedef struct {
        bit b;
        bit last;
    } sb_t;

    logic i_clk;
    logic i_arst_n;
    int   checks;
    int   errors;
    int   hs_cnt;
    int   rdy_mode;
    sb_t  sbq[$];
    vec_t vecs[8];

    u_tx_if #(.W(W)) bus ();

    u_tx #(.W(W)) dut (
        .i_clk   (i_clk),
        .i_arst_n(i_arst_n),
        .bus     (bus.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Downstream ready generator. It updates just after each rising edge.
    initial begin
        int ph;
        ph = 0;
        bus.i_ser_rdy = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            ph++;
            case (rdy_mode)
                0:       bus.i_ser_rdy = 1'b1;
                1:       bus.i_ser_rdy = ((ph % 3) == 0);
                default: bus.i_ser_rdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Serial monitor. It samples on the falling edge: a valid&ready seen here is taken at the next rising edge.
    initial begin
        bit held_v, held_b, held_l;
        sb_t e;
        held_v = 1'b0;
        held_b = 1'b0;
        held_l = 1'b0;
        forever begin
            @(negedge i_clk);
            if (i_arst_n) begin
                if (held_v) begin
                    chk("stall_vld_hold", int'(bus.o_ser_vld), 1);
                    chk("stall_bit_hold", int'(bus.o_ser_bit), int'(held_b));
                    chk("stall_last_hold", int'(bus.o_ser_last), int'(held_l));
                end
                held_v = 1'b0;
                if (bus.o_ser_vld && bus.i_ser_rdy) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_bit", 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        chk("ser_bit", int'(bus.o_ser_bit), int'(e.b));
                        chk("ser_last", int'(bus.o_ser_last), int'(e.last));
                    end
                    hs_cnt++;
                end else if (bus.o_ser_vld) begin
                    held_v = 1'b1;
                    held_b = bus.o_ser_bit;
                    held_l = bus.o_ser_last;
                end
            end else begin
                held_v = 1'b0;
            end
        end
    end

    // Wait for ready, present one request, and queue its expected bits. The task is entered and left at posedge+1.
    task automatic send(input int c, input bit inv, input bit [W-1:0] exp, output time acc);
        int n;
        n = 0;
        while (!bus.o_in_rdy && n < 200) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        if (!bus.o_in_rdy) chk("accept_timeout", 1, 0);
        bus.i_in_vld = 1'b1;
        bus.i_in_cnt = CW'(c);
        bus.i_in_inv = inv;
        @(posedge i_clk);
        acc = $time;
        #1;
        bus.i_in_vld = 1'b0;
        for (int i = 0; i < W; i++) begin
            sb_t s;
            s.b    = exp[i];
            s.last = (i == W - 1);
            sbq.push_back(s);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((sbq.size() != 0 || bus.o_busy) && n < 300) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        if (sbq.size() != 0 || bus.o_busy) chk("done_timeout", 1, 0);
    endtask

    initial begin
        time t0, t1;
        int  n, base;
        checks   = 0;
        errors   = 0;
        hs_cnt   = 0;
        rdy_mode = 0;

        vecs[0] = '{cnt: 3,  inv: 1'b0, mode: 0, exp: 8'b0000_0111};
        vecs[1] = '{cnt: 0,  inv: 1'b0, mode: 0, exp: 8'b0000_0000};
        vecs[2] = '{cnt: 8,  inv: 1'b0, mode: 0, exp: 8'b1111_1111};
        vecs[3] = '{cnt: 12, inv: 1'b0, mode: 0, exp: 8'b1111_1111};
`ifdef U_TX_COMPLIMENT_EN
        vecs[4] = '{cnt: 5,  inv: 1'b1, mode: 0, exp: 8'b1110_0000};
        vecs[7] = '{cnt: 2,  inv: 1'b1, mode: 2, exp: 8'b1111_1100};
`else
        vecs[4] = '{cnt: 5,  inv: 1'b1, mode: 0, exp: 8'b0001_1111};
        vecs[7] = '{cnt: 2,  inv: 1'b1, mode: 2, exp: 8'b0000_0011};
`endif
        vecs[5] = '{cnt: 4,  inv: 1'b0, mode: 1, exp: 8'b0000_1111};
        vecs[6] = '{cnt: 7,  inv: 1'b0, mode: 2, exp: 8'b0111_1111};

        bus.i_in_vld = 1'b0;
        bus.i_in_cnt = '0;
        bus.i_in_inv = 1'b0;
        i_arst_n     = 1'b0;

        // Check the outputs while reset is held.
        #2;
        chk("rst_in_rdy", int'(bus.o_in_rdy), 1);
        chk("rst_ser_vld", int'(bus.o_ser_vld), 0);
        chk("rst_ser_bit", int'(bus.o_ser_bit), 0);
        chk("rst_ser_last", int'(bus.o_ser_last), 0);
        chk("rst_busy", int'(bus.o_busy), 0);
        repeat (2) @(posedge i_clk);
        #1;
        i_arst_n = 1'b1;
        @(posedge i_clk);
        #1;
        chk("post_rst_in_rdy", int'(bus.o_in_rdy), 1);
        chk("post_rst_busy", int'(bus.o_busy), 0);

        // Table-driven codes.
        for (int v = 0; v < 8; v++) begin
            rdy_mode = vecs[v].mode;
            send(vecs[v].cnt, vecs[v].inv, vecs[v].exp, t0);
            wait_done();
        end
        rdy_mode = 0;

        // Latency: the accepting cycle plus 8 SHIFT cycles, then ready returns.
        send(3, 1'b0, 8'b0000_0111, t0);
        chk("first_bit_vld", int'(bus.o_ser_vld), 1);
        chk("busy_in_shift", int'(bus.o_in_rdy), 0);
        n = 0;
        while (!bus.o_in_rdy && n < 50) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        chk("accept_to_rdy_cycles", n + 1, 9);
        wait_done();

        // Back-to-back requests: there is exactly one IDLE cycle between the codes, so acceptances are W+1 cycles apart.
        send(0, 1'b0, 8'b0000_0000, t0);
        send(8, 1'b0, 8'b1111_1111, t1);
        chk("b2b_accept_spacing", int'((t1 - t0) / 10), W + 1);
        wait_done();

        // A request raised during SHIFT, with different cnt/inv, is neither accepted nor used.
        send(7, 1'b0, 8'b0111_1111, t0);
        bus.i_in_vld = 1'b1;
        bus.i_in_cnt = CW'(1);
        bus.i_in_inv = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("no_accept_in_shift", int'(bus.o_in_rdy), 0);
            @(posedge i_clk);
            #1;
        end
        bus.i_in_vld = 1'b0;
        bus.i_in_inv = 1'b0;
        wait_done();
        chk("idle_after_ignored", int'(bus.o_in_rdy), 1);

        // Reset in the middle of a code, after 3 handshakes.
        base = hs_cnt;
        send(6, 1'b0, 8'b0011_1111, t0);
        n = 0;
        while (hs_cnt < base + 3 && n < 50) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        chk("mid_hs_reached", int'(hs_cnt >= base + 3), 1);
        #2;
        i_arst_n = 1'b0;
        #1;
        chk("mid_rst_in_rdy", int'(bus.o_in_rdy), 1);
        chk("mid_rst_ser_vld", int'(bus.o_ser_vld), 0);
        chk("mid_rst_ser_bit", int'(bus.o_ser_bit), 0);
        chk("mid_rst_ser_last", int'(bus.o_ser_last), 0);
        chk("mid_rst_busy", int'(bus.o_busy), 0);
        sbq.delete();
        @(posedge i_clk);
        #3;
        i_arst_n = 1'b1;
        @(posedge i_clk);
        #1;
        chk("mid_post_rst_in_rdy", int'(bus.o_in_rdy), 1);
        send(2, 1'b0, 8'b0000_0011, t0);
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Backstop that stops the run if it goes on too long.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/u_tx.md
Name: u_tx

Overview:
- Serial transmitter for unary/thermometer codes. It is the sending end of the link whose receiver deserialises W bits and runs the unary-admission check on them.
- Accepts a binary count over a valid/ready handshake. Emits the corresponding W-bit thermometer code LSB-first, one bit per accepted beat, with a last marker.
- When the optional feature is compiled in, it can emit the complimented code instead.

Parameters:
- W, 8, length in bits of each emitted unary code (W >= 2).
- CW, $clog2(W+1), width of the count input (localparam, derived from W).

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_arst_n  input  1  asynchronous active-low reset.
- i_in_vld  input  1  count request valid.
- i_in_cnt  input  CW  number of leading 1s in the code, range 0..W.
- i_in_inv  input  1  request the complimented code.
- o_in_rdy  output  1  request accepted when i_in_vld & o_in_rdy.
- o_ser_vld  output  1  serial bit valid.
- o_ser_bit  output  1  serial data bit.
- o_ser_last  output  1  marks bit index W-1 of the current code.
- i_ser_rdy  input  1  downstream accepts the bit when o_ser_vld & i_ser_rdy.
- o_busy  output  1  a code is in flight (state != IDLE).

Behaviour:
- Reset: i_arst_n low asynchronously forces state=IDLE, idx=0, cnt_r=0, inv_r=0.
  - Outputs while in reset and after release: o_in_rdy=1, o_ser_vld=0, o_ser_bit=0, o_ser_last=0, o_busy=0.
- FSM has two states, IDLE and SHIFT.
- IDLE:
  - o_in_rdy=1, o_ser_vld=0.
  - On i_in_vld=1: latch cnt_r = min(i_in_cnt, W). Counts above W saturate to W.
  - Also latch inv_r = i_in_inv (see Optional Feature), set idx=0, go to SHIFT.
- SHIFT:
  - o_in_rdy=0, o_ser_vld=1.
  - o_ser_bit = (idx < cnt_r) XOR inv_r.
  - o_ser_last = (idx == W-1).
  - On handshake (i_ser_rdy=1): if o_ser_last, go to IDLE and clear idx; otherwise idx=idx+1.
  - With i_ser_rdy=0: o_ser_bit, o_ser_last and idx hold unchanged. No bit is dropped or repeated.
- Latency and throughput:
  - First bit is presented the cycle after request acceptance.
  - A code takes exactly W handshakes.
  - One IDLE cycle between consecutive codes: peak throughput is W bits per W+1 cycles.
- Width rules:
  - idx is CW bits wide.
  - The comparison idx < cnt_r is unsigned and done at CW bits.
  - idx never exceeds W-1, so no wrap-around is possible.
- Boundaries:
  - cnt=0 emits all 0s.
  - cnt=W emits all 1s.
  - cnt>W is clamped to W; there is no error indication.
  - i_in_vld asserted during SHIFT is ignored: no handshake occurs and the input holds per protocol.
  - i_in_cnt and i_in_inv are sampled only at acceptance. Changes during SHIFT have no effect.
  - Reset asserted mid-code aborts the code immediately. The next code starts from idx=0 after release.
- The emitted W-bit sequence, as the receiver assembles it (bit 0 first), is always a valid thermometer code. When inv_r=1 it is the valid complimented code.

Optional Feature:
- Macro U_TX_COMPLIMENT_EN.
- Defined: i_in_inv is latched into inv_r at acceptance, and the complimented code is emitted (first cnt bits 0, remainder 1).
- Undefined: inv_r is tied to 0, i_in_inv is ignored, and only the standard code is emitted. The port remains present so the interface is identical in both builds.

Test Plan:
- W=8, cnt=3, inv=0, i_ser_rdy=1 constant:
  - Bits 1,1,1,0,0,0,0,0.
  - o_ser_last only on the 8th bit.
  - o_in_rdy returns high 1 cycle after the last handshake.
  - 9 cycles total from acceptance to o_in_rdy high.
- W=8, cnt=0 then cnt=8 back-to-back requests: all-0 code, one IDLE cycle, then all-1 code.
- W=8, cnt=12: saturates, emits 8 ones.
- W=8, cnt=5, inv=1:
  - With U_TX_COMPLIMENT_EN defined: 0,0,0,0,0,1,1,1.
  - Without it: 1,1,1,1,1,0,0,0.
- W=8, cnt=4, i_ser_rdy toggling 1,0,0,1,...: each bit held stable while stalled; exact sequence 1,1,1,1,0,0,0,0 delivered with no duplication.
- W=8, cnt=6, i_arst_n pulsed low after 3 handshakes:
  - Outputs go to reset values asynchronously.
  - After release, o_in_rdy=1.
  - A new request cnt=2 emits 1,1,0,0,0,0,0,0 starting at idx 0.
